// File: rtl/axi_sram_responder_pkg.sv
// Shared types and constants for the AXI3 SRAM responder.
package axi_sram_responder_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned STRB_W  = DATA_W / 8;

  localparam logic [RESP_W-1:0] OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] DECERR = 2'b11;

  localparam logic [BURST_W-1:0] FIXED = 2'b00;
  localparam logic [BURST_W-1:0] INCR  = 2'b01;
  localparam logic [BURST_W-1:0] WRAP  = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Per-burst context latched at the address handshake.
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic [LEN_W-1:0]   cnt;
  } beat_ctx_t;

  // Worst-of merge: SLVERR dominates DECERR, which dominates OKAY.
  function automatic logic [RESP_W-1:0] resp_merge(input logic [RESP_W-1:0] a,
                                                   input logic [RESP_W-1:0] b);
    if (a == SLVERR || b == SLVERR) return SLVERR;
    if (a == DECERR || b == DECERR) return DECERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address and burst legality for one AXI address channel.
module axi_burst_addr_gen
  import axi_sram_responder_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr,
  input  logic [SIZE_W-1:0]  size,
  input  logic [LEN_W-1:0]   len,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  next_addr_c,
  output logic               err_c
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_len_ok;

  // Step, wrap container and burst-type address select.
  always_comb begin
    step        = ADDR_W'(1) << size;
    incr_addr   = addr + step;
    wrap_mask   = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    wrap_len_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                  (len == LEN_W'(7)) || (len == LEN_W'(15));
    next_addr_c = incr_addr;
    case (burst)
      FIXED:   next_addr_c = addr;
      INCR:    next_addr_c = incr_addr;
      WRAP:    next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr_c = incr_addr;
    endcase
    // Bus is 32 bits wide; reserved burst type is treated as a slave error.
    err_c = (size > SIZE_W'(2)) ||
            (burst == WRAP && !wrap_len_ok) ||
            (burst == 2'b11);
  end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 responder backed by a word-organised SRAM; independent single-outstanding
// read and write channels with programmable read latency.
// Optional macro AXI_SRAM_RESPONDER_STALL_EN: LFSR-driven random back-pressure.
module axi_sram_responder
  import axi_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  io_axi_ar_bits_id,
  input  logic [31:0] io_axi_ar_bits_addr,
  input  logic [7:0]  io_axi_ar_bits_len,
  input  logic [2:0]  io_axi_ar_bits_size,
  input  logic [1:0]  io_axi_ar_bits_burst,
  input  logic [1:0]  io_axi_ar_bits_lock,
  input  logic [3:0]  io_axi_ar_bits_cache,
  input  logic [2:0]  io_axi_ar_bits_prot,
  input  logic        io_axi_ar_valid,
  output logic        io_axi_ar_ready,
  output logic [3:0]  io_axi_r_bits_id,
  output logic [31:0] io_axi_r_bits_data,
  output logic [1:0]  io_axi_r_bits_resp,
  output logic        io_axi_r_bits_last,
  output logic        io_axi_r_valid,
  input  logic        io_axi_r_ready,
  input  logic [3:0]  io_axi_aw_bits_id,
  input  logic [31:0] io_axi_aw_bits_addr,
  input  logic [7:0]  io_axi_aw_bits_len,
  input  logic [2:0]  io_axi_aw_bits_size,
  input  logic [1:0]  io_axi_aw_bits_burst,
  input  logic [1:0]  io_axi_aw_bits_lock,
  input  logic [3:0]  io_axi_aw_bits_cache,
  input  logic [2:0]  io_axi_aw_bits_prot,
  input  logic        io_axi_aw_valid,
  output logic        io_axi_aw_ready,
  input  logic [3:0]  io_axi_w_bits_id,
  input  logic [31:0] io_axi_w_bits_data,
  input  logic [3:0]  io_axi_w_bits_strb,
  input  logic        io_axi_w_bits_last,
  input  logic        io_axi_w_valid,
  output logic        io_axi_w_ready,
  output logic [3:0]  io_axi_b_bits_id,
  output logic [1:0]  io_axi_b_bits_resp,
  output logic        io_axi_b_valid,
  input  logic        io_axi_b_ready
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WAIT_W = 4;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Lock/cache/prot and W id carry no meaning for this memory model.
  logic unused_ok;
  assign unused_ok = ^{io_axi_ar_bits_lock, io_axi_ar_bits_cache, io_axi_ar_bits_prot,
                       io_axi_aw_bits_lock, io_axi_aw_bits_cache, io_axi_aw_bits_prot,
                       io_axi_w_bits_id};

  // ---------------------------------------------------------------- stalls
  logic stall_ar, stall_aw, stall_w, stall_r;

`ifdef AXI_SRAM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1; each handshake signal owns one tap.
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // LFSR state register.
  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign stall_ar = lfsr_d[0];
  assign stall_aw = lfsr_d[3];
  assign stall_w  = lfsr_d[7];
  assign stall_r  = lfsr_d[11];
`else
  assign stall_ar = 1'b0;
  assign stall_aw = 1'b0;
  assign stall_w  = 1'b0;
  assign stall_r  = 1'b0;
`endif

  // ---------------------------------------------------------------- read side
  r_state_t          r_state_q, r_state_d;
  beat_ctx_t         r_ctx_q, r_ctx_d;
  logic [WAIT_W-1:0] r_wait_q, r_wait_d;
  logic              ar_ready_q, ar_ready_d;
  logic              r_valid_q, r_valid_d;
  logic [ID_W-1:0]   r_id_q;
  logic [DATA_W-1:0] r_data_q;
  logic [RESP_W-1:0] r_resp_q, r_resp_new;
  logic              r_last_q;
  logic              r_load;
  logic [ADDR_W-1:0] r_load_addr, r_off, r_next_addr;
  logic              r_hit, r_gen_err;
  logic [ADDR_W-1:0] r_gen_addr;
  logic [SIZE_W-1:0] r_gen_size;
  logic [LEN_W-1:0]  r_gen_len;
  logic [BURST_W-1:0] r_gen_burst;
  logic              ar_hs, r_hs;

  assign ar_hs = io_axi_ar_valid && ar_ready_q;
  assign r_hs  = r_valid_q && io_axi_r_ready;

  // In idle the checker sees the incoming AR so the first beat's response is known.
  always_comb begin
    if (r_state_q == R_IDLE) begin
      r_gen_addr  = io_axi_ar_bits_addr;
      r_gen_size  = io_axi_ar_bits_size;
      r_gen_len   = io_axi_ar_bits_len;
      r_gen_burst = io_axi_ar_bits_burst;
    end else begin
      r_gen_addr  = r_ctx_q.addr;
      r_gen_size  = r_ctx_q.size;
      r_gen_len   = r_ctx_q.len;
      r_gen_burst = r_ctx_q.burst;
    end
  end

  axi_burst_addr_gen u_rd_addr_gen (
    .addr        (r_gen_addr),
    .size        (r_gen_size),
    .len         (r_gen_len),
    .burst       (r_gen_burst),
    .next_addr_c (r_next_addr),
    .err_c       (r_gen_err)
  );

  // Read FSM next-state, beat context and registered-output next values.
  always_comb begin
    r_state_d   = r_state_q;
    r_ctx_d     = r_ctx_q;
    r_wait_d    = r_wait_q;
    r_load      = 1'b0;
    r_load_addr = r_ctx_q.addr;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_ctx_d.id    = io_axi_ar_bits_id;
          r_ctx_d.addr  = io_axi_ar_bits_addr;
          r_ctx_d.len   = io_axi_ar_bits_len;
          r_ctx_d.size  = io_axi_ar_bits_size;
          r_ctx_d.burst = io_axi_ar_bits_burst;
          r_ctx_d.cnt   = io_axi_ar_bits_len;
          if (READ_LAT <= 1) begin
            r_state_d   = R_DATA;
            r_load      = 1'b1;
            r_load_addr = io_axi_ar_bits_addr;
          end else begin
            r_state_d = R_WAIT;
            r_wait_d  = WAIT_W'(READ_LAT - 2);
          end
        end
      end
      R_WAIT: begin
        if (r_wait_q == '0) begin
          r_state_d = R_DATA;
          r_load    = 1'b1;
        end else begin
          r_wait_d = r_wait_q - WAIT_W'(1);
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (r_ctx_q.cnt == '0) begin
            r_state_d = R_IDLE;
          end else begin
            r_ctx_d.addr = r_next_addr;
            r_ctx_d.cnt  = r_ctx_q.cnt - LEN_W'(1);
            r_load       = 1'b1;
            r_load_addr  = r_next_addr;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ar_ready_d = (r_state_d == R_IDLE) && !stall_ar;
    // A presented beat stays valid until taken; only a fresh beat may be stalled.
    r_valid_d  = (r_state_d == R_DATA) && ((r_valid_q && !r_hs) || !stall_r);
  end

  // Range check and response for the beat being loaded into the R registers.
  always_comb begin
    r_off      = r_load_addr - BASE_ADDR;
    r_hit      = (r_off >> (IDX_W + 2)) == '0;
    r_resp_new = r_gen_err ? SLVERR : (r_hit ? OKAY : DECERR);
  end

  // Read state and R channel registers; data sampled before any same-cycle write.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q  <= R_IDLE;
      r_ctx_q    <= '0;
      r_wait_q   <= '0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= OKAY;
      r_last_q   <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_ctx_q    <= r_ctx_d;
      r_wait_q   <= r_wait_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      if (r_load) begin
        r_id_q   <= r_ctx_d.id;
        r_data_q <= (r_resp_new == OKAY) ? mem[r_off[IDX_W+1:2]] : '0;
        r_resp_q <= r_resp_new;
        r_last_q <= (r_ctx_d.cnt == '0);
      end
    end
  end

  assign io_axi_ar_ready    = ar_ready_q;
  assign io_axi_r_valid     = r_valid_q;
  assign io_axi_r_bits_id   = r_id_q;
  assign io_axi_r_bits_data = r_data_q;
  assign io_axi_r_bits_resp = r_resp_q;
  assign io_axi_r_bits_last = r_last_q;

  // ---------------------------------------------------------------- write side
  w_state_t           w_state_q, w_state_d;
  beat_ctx_t          w_ctx_q, w_ctx_d;
  logic               w_over_q, w_over_d;
  logic [RESP_W-1:0]  w_resp_q, w_resp_d, w_beat_resp;
  logic               aw_ready_q, aw_ready_d;
  logic               w_ready_q, w_ready_d;
  logic               b_valid_q, b_valid_d;
  logic [ID_W-1:0]    b_id_q;
  logic [RESP_W-1:0]  b_resp_q;
  logic               aw_hs, w_hs, b_hs;
  logic               w_mismatch, mem_we, w_hit, w_gen_err;
  logic [ADDR_W-1:0]  w_off, w_next_addr, w_gen_addr;
  logic [SIZE_W-1:0]  w_gen_size;
  logic [LEN_W-1:0]   w_gen_len;
  logic [BURST_W-1:0] w_gen_burst;

  assign aw_hs = io_axi_aw_valid && aw_ready_q;
  assign w_hs  = io_axi_w_valid && w_ready_q;
  assign b_hs  = b_valid_q && io_axi_b_ready;

  // In idle the checker sees the incoming AW so a bad burst is flagged up front.
  always_comb begin
    if (w_state_q == W_IDLE) begin
      w_gen_addr  = io_axi_aw_bits_addr;
      w_gen_size  = io_axi_aw_bits_size;
      w_gen_len   = io_axi_aw_bits_len;
      w_gen_burst = io_axi_aw_bits_burst;
    end else begin
      w_gen_addr  = w_ctx_q.addr;
      w_gen_size  = w_ctx_q.size;
      w_gen_len   = w_ctx_q.len;
      w_gen_burst = w_ctx_q.burst;
    end
  end

  axi_burst_addr_gen u_wr_addr_gen (
    .addr        (w_gen_addr),
    .size        (w_gen_size),
    .len         (w_gen_len),
    .burst       (w_gen_burst),
    .next_addr_c (w_next_addr),
    .err_c       (w_gen_err)
  );

  // Write FSM next-state, sticky response, SRAM write enable and output next values.
  always_comb begin
    w_state_d   = w_state_q;
    w_ctx_d     = w_ctx_q;
    w_over_d    = w_over_q;
    w_resp_d    = w_resp_q;
    w_beat_resp = OKAY;
    w_mismatch  = 1'b0;
    mem_we      = 1'b0;
    w_off       = w_ctx_q.addr - BASE_ADDR;
    w_hit       = (w_off >> (IDX_W + 2)) == '0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_ctx_d.id    = io_axi_aw_bits_id;
          w_ctx_d.addr  = io_axi_aw_bits_addr;
          w_ctx_d.len   = io_axi_aw_bits_len;
          w_ctx_d.size  = io_axi_aw_bits_size;
          w_ctx_d.burst = io_axi_aw_bits_burst;
          w_ctx_d.cnt   = io_axi_aw_bits_len;
          w_over_d      = 1'b0;
          w_resp_d      = w_gen_err ? SLVERR : OKAY;
          w_state_d     = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_beat_resp = w_gen_err ? SLVERR : (w_hit ? OKAY : DECERR);
          mem_we      = !w_over_q && (w_beat_resp == OKAY);
          // Early wlast, or the counter ran out (now or earlier) without wlast.
          w_mismatch  = io_axi_w_bits_last ? (!w_over_q && (w_ctx_q.cnt != '0))
                                           : (w_over_q || (w_ctx_q.cnt == '0));
          w_resp_d    = resp_merge(resp_merge(w_resp_q, w_beat_resp),
                                   w_mismatch ? SLVERR : OKAY);
          if (io_axi_w_bits_last) begin
            w_state_d = W_RESP;
          end else if (w_ctx_q.cnt == '0) begin
            w_over_d = 1'b1;
          end else if (!w_over_q) begin
            w_ctx_d.addr = w_next_addr;
            w_ctx_d.cnt  = w_ctx_q.cnt - LEN_W'(1);
          end
        end
      end
      W_RESP: begin
        if (b_hs) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE) && !stall_aw;
    w_ready_d  = (w_state_d == W_DATA) && !stall_w;
    b_valid_d  = (w_state_d == W_RESP);
  end

  // Write state and AW/W/B channel registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      w_ctx_q    <= '0;
      w_over_q   <= 1'b0;
      w_resp_q   <= OKAY;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= OKAY;
    end else begin
      w_state_q  <= w_state_d;
      w_ctx_q    <= w_ctx_d;
      w_over_q   <= w_over_d;
      w_resp_q   <= w_resp_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      if (w_state_q == W_DATA && w_state_d == W_RESP) begin
        b_id_q   <= w_ctx_q.id;
        b_resp_q <= w_resp_d;
      end
    end
  end

  // Byte-strobed SRAM write; contents are never reset.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (io_axi_w_bits_strb[b]) mem[w_off[IDX_W+1:2]][8*b +: 8] <= io_axi_w_bits_data[8*b +: 8];
      end
    end
  end

  assign io_axi_aw_ready    = aw_ready_q;
  assign io_axi_w_ready     = w_ready_q;
  assign io_axi_b_valid     = b_valid_q;
  assign io_axi_b_bits_id   = b_id_q;
  assign io_axi_b_bits_resp = b_resp_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed self-checking bench for axi_sram_responder (BASE 0x8000_0000, READ_LAT 3).
module tb_axi_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned LAT  = 3;
  localparam logic [1:0] B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10;

  logic        clock, reset;
  logic [3:0]  ar_id;   logic [31:0] ar_addr; logic [7:0] ar_len; logic [2:0] ar_size;
  logic [1:0]  ar_burst; logic ar_valid, ar_ready;
  logic [3:0]  r_id;    logic [31:0] r_data;  logic [1:0] r_resp; logic r_last, r_valid, r_ready;
  logic [3:0]  aw_id;   logic [31:0] aw_addr; logic [7:0] aw_len; logic [2:0] aw_size;
  logic [1:0]  aw_burst; logic aw_valid, aw_ready;
  logic [31:0] w_data;  logic [3:0] w_strb; logic w_last, w_valid, w_ready;
  logic [3:0]  b_id;    logic [1:0] b_resp; logic b_valid, b_ready;

  int n_cmp = 0;
  int n_err = 0;

  axi_sram_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(BASE), .READ_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .io_axi_ar_bits_id(ar_id), .io_axi_ar_bits_addr(ar_addr), .io_axi_ar_bits_len(ar_len),
    .io_axi_ar_bits_size(ar_size), .io_axi_ar_bits_burst(ar_burst),
    .io_axi_ar_bits_lock(2'b00), .io_axi_ar_bits_cache(4'h0), .io_axi_ar_bits_prot(3'h0),
    .io_axi_ar_valid(ar_valid), .io_axi_ar_ready(ar_ready),
    .io_axi_r_bits_id(r_id), .io_axi_r_bits_data(r_data), .io_axi_r_bits_resp(r_resp),
    .io_axi_r_bits_last(r_last), .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready),
    .io_axi_aw_bits_id(aw_id), .io_axi_aw_bits_addr(aw_addr), .io_axi_aw_bits_len(aw_len),
    .io_axi_aw_bits_size(aw_size), .io_axi_aw_bits_burst(aw_burst),
    .io_axi_aw_bits_lock(2'b00), .io_axi_aw_bits_cache(4'h0), .io_axi_aw_bits_prot(3'h0),
    .io_axi_aw_valid(aw_valid), .io_axi_aw_ready(aw_ready),
    .io_axi_w_bits_id(4'h0), .io_axi_w_bits_data(w_data), .io_axi_w_bits_strb(w_strb),
    .io_axi_w_bits_last(w_last), .io_axi_w_valid(w_valid), .io_axi_w_ready(w_ready),
    .io_axi_b_bits_id(b_id), .io_axi_b_bits_resp(b_resp), .io_axi_b_valid(b_valid),
    .io_axi_b_ready(b_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic axi_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
    while (!aw_ready && n < 100) begin tick(); n++; end
    if (!aw_ready) check_val("aw_timeout", 32'(aw_ready), 32'd1);
    tick();
    aw_valid = 1'b0;
  endtask

  task automatic axi_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    while (!w_ready && n < 100) begin tick(); n++; end
    if (!w_ready) check_val("w_timeout", 32'(w_ready), 32'd1);
    tick();
    w_valid = 1'b0;
  endtask

  task automatic axi_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
    while (!ar_ready && n < 100) begin tick(); n++; end
    if (!ar_ready) check_val("ar_timeout", 32'(ar_ready), 32'd1);
    tick();
    ar_valid = 1'b0;
  endtask

  task automatic get_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    b_ready = 1'b1;
    while (!b_valid && n < 100) begin tick(); n++; end
    check_val({tag, "_bvalid"}, 32'(b_valid), 32'd1);
    check_val({tag, "_bid"}, 32'(b_id), 32'(id));
    check_val({tag, "_bresp"}, 32'(b_resp), 32'(resp));
    tick();
    b_ready = 1'b0;
  endtask

  task automatic get_r(input string tag, input logic [31:0] data, input logic [1:0] resp,
                       input logic last, input logic [3:0] id);
    int n = 0;
    r_ready = 1'b1;
    while (!r_valid && n < 100) begin tick(); n++; end
    check_val({tag, "_rvalid"}, 32'(r_valid), 32'd1);
    check_val({tag, "_rdata"}, r_data, data);
    check_val({tag, "_rresp"}, 32'(r_resp), 32'(resp));
    check_val({tag, "_rlast"}, 32'(r_last), 32'(last));
    check_val({tag, "_rid"}, 32'(r_id), 32'(id));
    tick();
    r_ready = 1'b0;
  endtask

  initial begin
    int lat, beat, cyc;
    logic rr, held;
    logic [31:0] hold_data;
    logic [31:0] wrap_exp [4];

    reset = 1'b1;
    ar_valid = 0; aw_valid = 0; w_valid = 0; r_ready = 0; b_ready = 0;
    ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
    aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_data = 0; w_strb = 0; w_last = 0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset values.
    check_val("rst_arready", 32'(ar_ready), 32'd1);
    check_val("rst_awready", 32'(aw_ready), 32'd1);
    check_val("rst_wready", 32'(w_ready), 32'd0);
    check_val("rst_rvalid", 32'(r_valid), 32'd0);
    check_val("rst_bvalid", 32'(b_valid), 32'd0);
    check_val("rst_rdata", r_data, 32'd0);
    check_val("rst_rmisc", {24'd0, r_id, r_resp, 1'b0, r_last}, 32'd0);
    check_val("rst_bmisc", {26'd0, b_id, b_resp}, 32'd0);

    // Single write then single read, with exact read latency.
    axi_aw(4'd5, BASE + 32'h10, 8'd0, 3'd2, B_INCR);
    axi_w(32'hDEADBEEF, 4'hF, 1'b1);
    get_b("single", 4'd5, 2'b00);
    axi_ar(4'd9, BASE + 32'h10, 8'd0, 3'd2, B_INCR);
    check_val("ar_busy", 32'(ar_ready), 32'd0);
    lat = 1;
    while (!r_valid && lat < 20) begin tick(); lat++; end
    check_val("read_latency", 32'(lat), 32'(LAT));
    get_r("single", 32'hDEADBEEF, 2'b00, 1'b1, 4'd9);

    // Fill words 8..15 with an INCR burst, then read back with rready toggling.
    axi_aw(4'd1, BASE + 32'h20, 8'd7, 3'd2, B_INCR);
    for (int i = 0; i < 8; i++) axi_w(32'hA000_0000 + 32'(i), 4'hF, i == 7);
    get_b("fill", 4'd1, 2'b00);
    axi_ar(4'd2, BASE + 32'h20, 8'd7, 3'd2, B_INCR);
    beat = 0; cyc = 0; rr = 1'b0; held = 1'b0; hold_data = '0;
    while (beat < 8 && cyc < 200) begin
      r_ready = rr;
      if (held) begin
        check_val("incr_hold_valid", 32'(r_valid), 32'd1);
        check_val("incr_hold_data", r_data, hold_data);
      end
      held = 1'b0;
      if (r_valid) begin
        if (rr) begin
          check_val("incr_data", r_data, 32'hA000_0000 + 32'(beat));
          check_val("incr_last", 32'(r_last), 32'(beat == 7));
          check_val("incr_resp", 32'(r_resp), 32'd0);
          beat++;
        end else begin
          held = 1'b1;
          hold_data = r_data;
        end
      end
      tick();
      cyc++;
      rr = ~rr;
    end
    r_ready = 1'b0;
    check_val("incr_beats", 32'(beat), 32'd8);

    // WRAP len=3 from 0x38 visits 0x38,0x3C,0x30,0x34 = words 14,15,12,13.
    wrap_exp[0] = 32'hA000_0006; wrap_exp[1] = 32'hA000_0007;
    wrap_exp[2] = 32'hA000_0004; wrap_exp[3] = 32'hA000_0005;
    axi_ar(4'd3, BASE + 32'h38, 8'd3, 3'd2, B_WRAP);
    for (int i = 0; i < 4; i++) get_r("wrap", wrap_exp[i], 2'b00, i == 3, 4'd3);

    // Partial strobe merge over all-ones.
    axi_aw(4'd4, BASE + 32'h40, 8'd0, 3'd2, B_INCR);
    axi_w(32'hFFFF_FFFF, 4'hF, 1'b1);
    get_b("pre_ff", 4'd4, 2'b00);
    axi_aw(4'd4, BASE + 32'h40, 8'd0, 3'd2, B_FIXED);
    axi_w(32'h1122_3344, 4'b0101, 1'b1);
    get_b("strb", 4'd4, 2'b00);
    axi_ar(4'd4, BASE + 32'h40, 8'd0, 3'd2, B_INCR);
    get_r("strb", 32'hFF22_FF44, 2'b00, 1'b1, 4'd4);

    // Read one past the top of the SRAM decodes as an error and returns zero.
    axi_ar(4'd6, BASE + 32'h4000, 8'd0, 3'd2, B_INCR);
    get_r("decerr", 32'd0, 2'b11, 1'b1, 4'd6);

    // Oversized write is rejected and leaves memory untouched.
    axi_aw(4'd7, BASE + 32'h50, 8'd0, 3'd2, B_INCR);
    axi_w(32'h1234_5678, 4'hF, 1'b1);
    get_b("pre_50", 4'd7, 2'b00);
    axi_aw(4'd7, BASE + 32'h50, 8'd0, 3'd3, B_INCR);
    axi_w(32'h0000_0000, 4'hF, 1'b1);
    get_b("size3", 4'd7, 2'b10);
    axi_ar(4'd7, BASE + 32'h50, 8'd0, 3'd2, B_INCR);
    get_r("size3_kept", 32'h1234_5678, 2'b00, 1'b1, 4'd7);

    // Early wlast on a 2-beat burst: SLVERR, but the in-range first beat is written.
    axi_aw(4'd8, BASE + 32'h60, 8'd1, 3'd2, B_INCR);
    axi_w(32'hCAFE_0001, 4'hF, 1'b1);
    get_b("early_last", 4'd8, 2'b10);
    axi_ar(4'd8, BASE + 32'h60, 8'd0, 3'd2, B_INCR);
    get_r("early_last", 32'hCAFE_0001, 2'b00, 1'b1, 4'd8);

    // Reset during beat 3 of an 8-beat write.
    axi_aw(4'd10, BASE + 32'h80, 8'd7, 3'd2, B_INCR);
    axi_w(32'h0000_0B01, 4'hF, 1'b0);
    axi_w(32'h0000_0B02, 4'hF, 1'b0);
    w_data = 32'h0000_0B03; w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    w_valid = 1'b0;
    check_val("midrst_awready", 32'(aw_ready), 32'd1);
    check_val("midrst_bvalid", 32'(b_valid), 32'd0);
    check_val("midrst_wready", 32'(w_ready), 32'd0);
    repeat (3) tick();
    check_val("midrst_no_b", 32'(b_valid), 32'd0);
    axi_aw(4'd11, BASE + 32'h80, 8'd0, 3'd2, B_INCR);
    axi_w(32'h5A5A_5A5A, 4'hF, 1'b1);
    get_b("post_rst", 4'd11, 2'b00);
    axi_ar(4'd12, BASE + 32'h80, 8'd0, 3'd2, B_INCR);
    get_r("post_rst", 32'h5A5A_5A5A, 2'b00, 1'b1, 4'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
